// File: rtl/pio_in_irq.sv
// Avalon-MM input PIO: synchronised WIDTH-bit input, per-bit edge capture, interrupt mask, level IRQ.
// Define PIO_IN_DEBOUNCE_EN to add a per-bit debounce filter of DEBOUNCE_CYCLES stable cycles.
module pio_in_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int            GW        = $clog2(SYNC_STAGES + 2);
  localparam logic [GW-1:0] GUARD_MAX = GW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [GW-1:0]    r_guard;
  logic             w_armed;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_armed  = (r_guard == GUARD_MAX);
  assign w_wr     = chipselect & write;
  assign w_unused = ^{writedata, DEBOUNCE_CYCLES[0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int            CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_db_cnt [WIDTH];
  logic [WIDTH-1:0] r_filt;

  // NOTE: these counters are plain flops, not a RAM, so resetting the whole array is cheap and safe.
  // While the startup guard runs, filt tracks sync_q so a pin held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= '0;
      for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_armed) begin
          r_filt[i]   <= w_sync_q[i];
          r_db_cnt[i] <= '0;
        end else if (w_sync_q[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_MAX) begin
          r_filt[i]   <= w_sync_q[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = w_sync_q;
`endif

  // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
  always_comb begin
    w_edge = '0;
    if (w_armed) begin
      case (EDGE_TYPE)
        0:       w_edge = w_filt & ~r_prev;
        1:       w_edge = ~w_filt & r_prev;
        default: w_edge = w_filt ^ r_prev;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = w_filt;
      2'd2:    w_rdata[WIDTH-1:0] = r_irq_mask;
      2'd3:    w_rdata[WIDTH-1:0] = r_edge_cap;
      default: ;
    endcase
  end

  // A new edge wins over a simultaneous write-clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_guard    <= '0;
      r_prev     <= '0;
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      readdata   <= '0;
    end else begin
      if (!w_armed) r_guard <= r_guard + 1'b1;
      r_prev <= w_armed ? w_filt : w_sync_q;
      if (w_wr && (address == 2'd2)) r_irq_mask <= writedata[WIDTH-1:0];
      if (w_wr && (address == 2'd3)) r_edge_cap <= (r_edge_cap & ~writedata[WIDTH-1:0]) | w_edge;
      else                           r_edge_cap <= r_edge_cap | w_edge;
      readdata <= w_rdata;
    end
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_pio_in_irq.sv
// Scoreboard bench for pio_in_irq: an 8-bit rising-edge instance and a 12-bit any-edge instance.
module tb_pio_in_irq;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address0 = '0, address1 = '0;
  logic        cs0 = 1'b0, cs1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [7:0]  in0 = 8'hFF;
  logic [11:0] in1 = 12'h000;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  logic rd_req0 = 1'b0, rd_req1 = 1'b0, rd_pend0 = 1'b0, rd_pend1 = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .address(address0), .chipselect(cs0), .write(wr0),
    .writedata(wd0), .in_port(in0), .readdata(rd0), .irq(irq0)
  );

  pio_in_irq #(.WIDTH(12), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut1 (
    .clk(clk), .reset(reset), .address(address1), .chipselect(cs1), .write(wr1),
    .writedata(wd1), .in_port(in1), .readdata(rd1), .irq(irq1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a read address and queue the expected readdata for the monitor.
  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string tag);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    if (d == 0) begin address0 = a; q0.push_back(it); rd_req0 = 1'b1; end
    else        begin address1 = a; q1.push_back(it); rd_req1 = 1'b1; end
    @(posedge clk);
    #1;
    rd_req0 = 1'b0;
    rd_req1 = 1'b0;
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
    if (d == 0) begin address0 = a; wd0 = data; cs0 = 1'b1; wr0 = 1'b1; end
    else        begin address1 = a; wd1 = data; cs1 = 1'b1; wr1 = 1'b1; end
    @(posedge clk);
    #1;
    cs0 = 1'b0; wr0 = 1'b0; cs1 = 1'b0; wr1 = 1'b0;
  endtask

  always @(posedge clk) begin
    rd_pend0 <= rd_req0;
    rd_pend1 <= rd_req1;
  end

  always @(negedge clk) begin
    if (rd_pend0 && q0.size() > 0) begin e0 = q0.pop_front(); check(e0.tag, rd0, e0.exp); end
    if (rd_pend1 && q1.size() > 0) begin e1 = q1.pop_front(); check(e1.tag, rd1, e1.exp); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_readdata", rd0, 32'h0);
    check("rst_irq0", {31'b0, irq0}, 32'h0);
    check("rst_irq1", {31'b0, irq1}, 32'h0);
    step(3);
    reset = 1'b0;
    step(10);
    rd(0, 2'd3, 32'h0, "cap_hold_hi");
    check("irq_hold_hi", {31'b0, irq0}, 32'h0);
    rd(0, 2'd0, 32'h0000_00FF, "data_hold_hi");

    in0 = 8'h00;
    step(LAT + 2);
    rd(0, 2'd0, 32'h0, "data_fall");
    rd(0, 2'd3, 32'h0, "no_fall_cap");

    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, 32'h1, "mask_rb");
    in0 = 8'h01;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("irq_early", {31'b0, irq0}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_rise", {31'b0, irq0}, 32'h1);
    rd(0, 2'd3, 32'h1, "cap_rise");
    wr(0, 2'd3, 32'h1);
    check("irq_clr", {31'b0, irq0}, 32'h0);
    rd(0, 2'd3, 32'h0, "cap_clr");

    in0 = 8'h05;
    repeat (LAT - 1) @(posedge clk);
    #1;
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h4, "collision");
    check("irq_bit2_masked", {31'b0, irq0}, 32'h0);
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h0, "clr_after_coll");
    wr(0, 2'd2, 32'hFFFF_FF00);
    rd(0, 2'd2, 32'h0, "mask_upper_ign");

    in0 = 8'h0D;
    step(LAT + 1);
    wr(0, 2'd2, 32'h8);
    check("irq_pre_rst", {31'b0, irq0}, 32'h1);
    reset = 1'b1;
    #1;
    check("irq_in_rst", {31'b0, irq0}, 32'h0);
    check("rd_in_rst", rd0, 32'h0);
    step(2);
    reset = 1'b0;
    step(10);
    rd(0, 2'd3, 32'h0, "cap_after_rst");
    rd(0, 2'd2, 32'h0, "mask_after_rst");
    rd(0, 2'd0, 32'h0D, "data_after_rst");

    in1 = 12'h008;
    step(LAT + 2);
    rd(1, 2'd3, 32'h008, "any_cap");
    check("irq_mask0", {31'b0, irq1}, 32'h0);
    wr(1, 2'd2, 32'h8);
    check("irq_unmask", {31'b0, irq1}, 32'h1);
    in1 = 12'hABC;
    step(LAT + 2);
    rd(1, 2'd0, 32'h0000_0ABC, "w12_data");
    rd(1, 2'd1, 32'h0, "w12_rsvd");
    rd(1, 2'd3, 32'h0000_0ABC, "w12_cap");
    wr(1, 2'd1, 32'hFFFF_FFFF);
    rd(1, 2'd1, 32'h0, "rsvd_wr");
    wr(1, 2'd2, 32'hFFFF_FFFF);
    rd(1, 2'd2, 32'h0000_0FFF, "w12_mask");
    wr(1, 2'd3, 32'hFFFF_FFFF);
    rd(1, 2'd3, 32'h0, "w12_clr");
    check("irq_w12_clr", {31'b0, irq1}, 32'h0);
    in1 = 12'hAB8;
    step(LAT + 2);
    rd(1, 2'd3, 32'h004, "any_fall");

`ifdef PIO_IN_DEBOUNCE_EN
    in0 = 8'h0C;
    step(40);
    wr(0, 2'd3, 32'hFF);
    rd(0, 2'd3, 32'h0, "db_pre_clr");
    in0 = 8'h0D;
    step(10);
    in0 = 8'h0C;
    step(30);
    rd(0, 2'd0, 32'h0C, "db_glitch_data");
    rd(0, 2'd3, 32'h0, "db_glitch_cap");
    in0 = 8'h0D;
    step(20);
    rd(0, 2'd0, 32'h0D, "db_long_data");
    rd(0, 2'd3, 32'h1, "db_long_cap");
    in0 = 8'h0C;
    step(30);
`endif

    step(3);
    check("sb_drain", q0.size() + q1.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
